// File: rtl/cxapbasyncbridge_cdc_launch.sv
// Source-side launch stage of the APB async bridge: captures a local word,
// then holds it stable while a 4-phase req/ack handshake crosses domains.
module cxapbasyncbridge_cdc_launch #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             req_async,
    input  logic             ack_async,
    output logic [WIDTH-1:0] data_async,
    output logic             busy,
    output logic             done
);

    generate
        if ((SYNC_STAGES != 2) && (SYNC_STAGES != 3)) begin : g_bad_sync_stages
            $error("cxapbasyncbridge_cdc_launch: SYNC_STAGES must be 2 or 3");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACKLO = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   req_q;
    logic [WIDTH-1:0]       data_q;
    logic                   done_q;
    logic                   run_q;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_s;
    logic                   accept;

    // ack_async is only ever sampled by the first synchronizer flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_async};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // Holds s_ready low while reset is asserted and for the first edge after it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign s_ready = run_q & (state_q == IDLE) & ~ack_s;
    assign accept  = s_valid & s_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= s_data;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        req_q   <= 1'b0;
                        state_q <= ACKLO;
                    end
                end
                ACKLO: begin
                    if (!ack_s) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Crossing outputs come straight from flops so the far side sees glitch-free values.
    assign req_async  = req_q;
    assign data_async = data_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule
